// File: rtl/pipe_valid_ctrl.sv
// Valid/ready controller for a NUM_STAGES deep pipeline with bubble collapsing and flush.
// Latency NUM_STAGES cycles; a stage stalls only when it and every stage after it are full.
module pipe_valid_ctrl #(
  parameter int NUM_STAGES = 8,
  parameter int CNT_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic [NUM_STAGES-1:0] ce,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  empty
);

  logic [NUM_STAGES-1:0] v;
  logic [NUM_STAGES-1:0] ivld;
  logic [NUM_STAGES:0]   rdy;
  logic                  in_xfer;
  logic                  out_xfer;
  logic [CNT_W-1:0]      occ_nxt;

  // Ready ripples from the output back to stage 0; an empty stage is always ready.
  always_comb begin
    rdy             = '0;
    rdy[NUM_STAGES] = out_ready;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      rdy[i] = !v[i] | rdy[i+1];
    end
  end

  always_comb begin
    ivld    = '0;
    ivld[0] = in_valid;
    for (int i = 1; i < NUM_STAGES; i++) begin
      ivld[i] = v[i-1];
    end
  end

  // ce is also gated by resetn so the datapath stays frozen while held in reset.
  assign ce        = ivld & rdy[NUM_STAGES-1:0] & {NUM_STAGES{!flush && resetn}};
  assign in_ready  = rdy[0] & !flush & resetn;
  assign out_valid = v[NUM_STAGES-1] & !flush;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    occ_nxt = occupancy;
    if (flush) begin
      occ_nxt = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_nxt = occupancy + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occ_nxt = occupancy - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v         <= '0;
      occupancy <= '0;
      empty     <= 1'b1;
    end else begin
      if (flush) begin
        v <= '0;
      end else begin
        v <= (v & ~rdy[NUM_STAGES-1:0]) | (ivld & rdy[NUM_STAGES-1:0]);
      end
      occupancy <= occ_nxt;
      empty     <= (occ_nxt == '0);
    end
  end

endmodule

// File: tb/tb_pipe_valid_ctrl.sv
// Bench for pipe_valid_ctrl (NUM_STAGES=4) with a ce-driven data pipe and an in-order scoreboard.
module tb_pipe_valid_ctrl;
  localparam int N = 4;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic [N-1:0]  ce;
  logic [CW-1:0] occupancy;
  logic          empty;

  logic [7:0] in_data = 8'h00;
  logic [7:0] dp [N];
  logic [7:0] q [$];
  int vectors = 0;
  int errors = 0;
  int occ_m = 0;
  int acc_cnt = 0;
  int out_cnt = 0;

  pipe_valid_ctrl #(.NUM_STAGES(N)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .ce(ce),
    .occupancy(occupancy), .empty(empty)
  );

  always #5 clk = ~clk;

  // Data pipe loaded only by ce, standing in for the controlled datapath.
  always @(posedge clk) begin
    for (int i = N - 1; i >= 0; i--) begin
      if (ce[i]) dp[i] <= (i == 0) ? in_data : dp[i-1];
    end
  end

  task automatic tick();
    logic [7:0] exp;
    bit adv;
    adv = 1'b0;
    @(negedge clk);
    if (in_valid && in_ready) begin
      q.push_back(in_data);
      acc_cnt++;
      occ_m++;
      adv = 1'b1;
    end
    if (out_valid && out_ready) begin
      out_cnt++;
      occ_m--;
      vectors++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra_word got=%02h expected=none", dp[N-1]);
      end else begin
        exp = q.pop_front();
        if (dp[N-1] !== exp) begin
          errors++;
          $display("FAIL sb_data got=%02h expected=%02h", dp[N-1], exp);
        end
      end
    end
    if (flush) begin
      q.delete();
      occ_m = 0;
    end
    @(posedge clk);
    #1;
    if (adv) in_data = in_data + 8'h01;
    vectors++;
    if (int'(occupancy) !== occ_m) begin
      errors++;
      $display("FAIL occupancy got=%0d expected=%0d", occupancy, occ_m);
    end
  endtask

  task automatic apply_reset();
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    q.delete();
    occ_m = 0;
    #1 resetn = 1'b1;
  endtask

  task automatic drain(input int target);
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (out_cnt < target && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (out_cnt !== target) begin
      errors++;
      $display("FAIL drain_count got=%0d expected=%0d", out_cnt, target);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (occupancy !== '0 || empty !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0 || ce !== '0) begin
      errors++;
      $display("FAIL reset_state occ=%0d empty=%b ov=%b ir=%b ce=%b expected 0/1/0/0/0000",
               occupancy, empty, out_valid, in_ready, ce);
    end
    in_valid = 1'b0;
    apply_reset();
  endtask

  task automatic test_streaming();
    int base;
    base = out_cnt;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 10);
      out_ready = 1'b1;
      #1;
      vectors++;
      if (out_valid !== (c >= 4 && c < 14)) begin
        errors++;
        $display("FAIL stream_out_valid cycle=%0d got=%b expected=%b", c, out_valid, (c >= 4 && c < 14));
      end
      if (c >= 4 && c < 10) begin
        vectors++;
        if (ce !== 4'b1111) begin
          errors++;
          $display("FAIL stream_ce cycle=%0d got=%b expected=1111", c, ce);
        end
      end
      tick();
    end
    vectors++;
    if (out_cnt - base !== 10) begin
      errors++;
      $display("FAIL stream_beats got=%0d expected=10", out_cnt - base);
    end
  endtask

  task automatic test_backpressure();
    int a0, o0;
    apply_reset();
    a0 = acc_cnt;
    o0 = out_cnt;
    in_valid = 1'b1;
    out_ready = 1'b0;
    repeat (8) tick();
    #1;
    vectors++;
    if (acc_cnt - a0 !== 4 || in_ready !== 1'b0 || occupancy !== 3'd4) begin
      errors++;
      $display("FAIL bp_full accepted=%0d in_ready=%b occ=%0d expected 4/0/4", acc_cnt - a0, in_ready, occupancy);
    end
    out_ready = 1'b1;
    while (acc_cnt - a0 < 6) begin
      if (acc_cnt - a0 > 6 || out_cnt - o0 > 8) break;
      tick();
    end
    drain(o0 + 6);
  endtask

  task automatic test_bubble();
    apply_reset();
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 11; c++) begin
      #1;
      vectors++;
      if (out_valid !== (c >= 4)) begin
        errors++;
        $display("FAIL bubble_out_valid cycle=%0d got=%b expected=%b", c, out_valid, (c >= 4));
      end
      if (c >= 4) begin
        vectors++;
        if (ce !== 4'b0000) begin
          errors++;
          $display("FAIL bubble_ce cycle=%0d got=%b expected=0000", c, ce);
        end
      end
      tick();
    end
    drain(out_cnt + 1);
  endtask

  task automatic test_full_simultaneous();
    apply_reset();
    in_valid = 1'b1;
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (in_ready !== 1'b1 || ce !== 4'b1111) begin
        errors++;
        $display("FAIL full_simul in_ready=%b ce=%b expected 1/1111", in_ready, ce);
      end
      tick();
      vectors++;
      if (occupancy !== 3'd4) begin
        errors++;
        $display("FAIL full_occ got=%0d expected=4", occupancy);
      end
    end
    drain(out_cnt + 4);
  endtask

  task automatic test_flush();
    apply_reset();
    in_valid = 1'b1;
    out_ready = 1'b0;
    repeat (3) tick();
    flush = 1'b1;
    #1;
    vectors++;
    if (ce !== 4'b0000 || in_ready !== 1'b0 || out_valid !== 1'b0 || occupancy !== 3'd3) begin
      errors++;
      $display("FAIL flush_comb ce=%b ir=%b ov=%b occ=%0d expected 0000/0/0/3", ce, in_ready, out_valid, occupancy);
    end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (occupancy !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL flush_after occ=%0d empty=%b expected 0/1", occupancy, empty);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    drain(out_cnt + 1);
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (6) tick();
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if (occupancy !== '0 || out_valid !== 1'b0 || empty !== 1'b1 || in_ready !== 1'b0 || ce !== '0) begin
      errors++;
      $display("FAIL async_reset occ=%0d ov=%b empty=%b ir=%b ce=%b expected 0/0/1/0/0000",
               occupancy, out_valid, empty, in_ready, ce);
    end
    in_valid = 1'b0;
    q.delete();
    occ_m = 0;
    @(posedge clk);
    #1 resetn = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== '0) begin
      errors++;
      $display("FAIL post_reset ov=%b occ=%0d expected 0/0", out_valid, occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_full_simultaneous();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
